// File: rtl/convn_valid_pkg.sv
// Shared constants and helpers for the convn_valid MAC datapath.
// sat_narrow works on a 64-bit carrier so one function serves every width.
package convn_valid_pkg;

   localparam int DIN0_W_DEF = 14;
   localparam int DIN1_W_DEF = 12;
   localparam int DOUT_W_DEF = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Caller keeps the low dw bits of the result.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int dw,
                                                      input bit sat);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (sat && (v > hi)) return hi;
      if (sat && (v < lo)) return lo;
      return v;
   endfunction

endpackage

// File: rtl/convn_valid_mul_pipe.sv
// Signed NUM_STAGE-deep multiplier with clock enable, sync flush and a
// valid/last sideband travelling alongside each product.
module convn_valid_mul_pipe #(
   parameter int A_W       = 14,
   parameter int B_W       = 12,
   parameter int NUM_STAGE = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_flush,
   input  logic               i_vld,
   input  logic               i_last,
   input  logic [A_W-1:0]     i_a,
   input  logic [B_W-1:0]     i_b,
   output logic               o_vld,
   output logic               o_last,
   output logic [A_W+B_W-1:0] o_prod,
   output logic               o_busy
);

   localparam int P_W = A_W + B_W;

   logic [NUM_STAGE:1] r_vld_pipe;
   logic [NUM_STAGE:1] r_last_pipe;
   logic [P_W-1:0]     r_prod_pipe [1:NUM_STAGE];

   logic signed [P_W-1:0] w_a;
   logic signed [P_W-1:0] w_b;
   logic signed [P_W-1:0] w_prod;

   assign w_a    = P_W'($signed(i_a));
   assign w_b    = P_W'($signed(i_b));
   assign w_prod = w_a * w_b;

   // Flush wins over the enable so an abort also lands during a stall.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         for (int s = 1; s <= NUM_STAGE; s++) r_prod_pipe[s] <= '0;
      end else if (i_flush) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else if (i_en) begin
         r_vld_pipe[1]  <= i_vld;
         r_last_pipe[1] <= i_vld & i_last;
         r_prod_pipe[1] <= w_prod;
         for (int s = 2; s <= NUM_STAGE; s++) begin
            r_vld_pipe[s]  <= r_vld_pipe[s-1];
            r_last_pipe[s] <= r_last_pipe[s-1];
            r_prod_pipe[s] <= r_prod_pipe[s-1];
         end
      end
   end

   assign o_vld  = r_vld_pipe[NUM_STAGE];
   assign o_last = r_last_pipe[NUM_STAGE];
   assign o_prod = r_prod_pipe[NUM_STAGE];
   assign o_busy = |r_vld_pipe;

endmodule

// File: rtl/convn_valid_mac_pipe.sv
// Windowed signed MAC: pipelined multiply, KLEN-tap accumulate, then a
// shifted and saturated/wrapped result per window on a valid/ready port.
module convn_valid_mac_pipe
   import convn_valid_pkg::*;
#(
   parameter int DIN0_WIDTH = DIN0_W_DEF,
   parameter int DIN1_WIDTH = DIN1_W_DEF,
   parameter int NUM_STAGE  = 2,
   parameter int KLEN       = 9,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_SHIFT  = 0,
   parameter int DOUT_WIDTH = DOUT_W_DEF,
   parameter bit SAT_EN     = 1'b1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  busy
);

   localparam int P_W   = DIN0_WIDTH + DIN1_WIDTH;
   localparam int CNT_W = (KLEN > 1) ? clog2(KLEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KLEN - 1);

   if (ACC_WIDTH < P_W + clog2(KLEN)) begin : g_err_acc
      $error("convn_valid_mac_pipe: ACC_WIDTH too narrow for operands and KLEN");
   end
   if (ACC_WIDTH > 64 || DOUT_WIDTH > 64) begin : g_err_w64
      $error("convn_valid_mac_pipe: ACC_WIDTH/DOUT_WIDTH above 64 unsupported");
   end
   if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_err_stage
      $error("convn_valid_mac_pipe: NUM_STAGE must be 1..4");
   end
   if (KLEN < 1 || KLEN > 1024) begin : g_err_klen
      $error("convn_valid_mac_pipe: KLEN must be 1..1024");
   end

   logic [CNT_W-1:0]             r_cnt;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic                         r_out_valid;
   logic [DOUT_WIDTH-1:0]        r_dout;

   logic                         w_stall;
   logic                         w_accept;
   logic                         w_last_in;
   logic                         w_tail_vld;
   logic                         w_tail_last;
   logic [P_W-1:0]               w_tail_prod;
   logic                         w_pipe_busy;
   logic                         w_done;
   logic signed [ACC_WIDTH-1:0]  w_sum;
   logic signed [ACC_WIDTH-1:0]  w_shifted;

   assign w_stall   = r_out_valid & ~out_ready;
   assign w_accept  = in_valid & ~w_stall;
   assign w_last_in = (r_cnt == LAST_CNT);

   convn_valid_mul_pipe #(
      .A_W       (DIN0_WIDTH),
      .B_W       (DIN1_WIDTH),
      .NUM_STAGE (NUM_STAGE)
   ) u_mul (
      .i_clk   (ap_clk),
      .i_rst_n (ap_rst_n),
      .i_en    (~w_stall),
      .i_flush (clr),
      .i_vld   (w_accept),
      .i_last  (w_last_in),
      .i_a     (din0),
      .i_b     (din1),
      .o_vld   (w_tail_vld),
      .o_last  (w_tail_last),
      .o_prod  (w_tail_prod),
      .o_busy  (w_pipe_busy)
   );

   assign w_sum     = r_acc + ACC_WIDTH'($signed(w_tail_prod));
   assign w_shifted = w_sum >>> OUT_SHIFT;
   assign w_done    = ~w_stall & ~clr & w_tail_vld & w_tail_last;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (clr) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (!w_stall) begin
         if (w_accept) r_cnt <= w_last_in ? '0 : r_cnt + CNT_W'(1);
         if (w_tail_vld) r_acc <= w_tail_last ? '0 : w_sum;
      end
   end

   // A result written on a handshake edge keeps out_valid high.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_out_valid <= 1'b0;
         r_dout      <= '0;
      end else if (w_done) begin
         r_out_valid <= 1'b1;
         r_dout      <= DOUT_WIDTH'(sat_narrow(64'(w_shifted), DOUT_WIDTH, SAT_EN));
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = ~w_stall;
   assign out_valid = r_out_valid;
   assign dout      = r_dout;
   assign busy      = (r_cnt != '0) | w_pipe_busy;

endmodule

// File: tb/tb_convn_valid_mac_pipe.sv
// Directed plus randomized bench for convn_valid_mac_pipe (KLEN=3, NUM_STAGE=2),
// one saturating and one wrapping instance driven in parallel.
module tb_convn_valid_mac_pipe;

   localparam int NS = 2;

   logic        ap_clk    = 1'b0;
   logic        ap_rst_n  = 1'b0;
   logic        clr       = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [13:0] din0      = '0;
   logic [11:0] din1      = '0;

   logic        s_in_ready, s_out_valid, s_busy;
   logic [15:0] s_dout;
   logic        w_in_ready, w_out_valid, w_busy;
   logic [15:0] w_dout;

   int n_vec = 0;
   int n_bad = 0;

   always #5 ap_clk = ~ap_clk;

   convn_valid_mac_pipe #(
      .DIN0_WIDTH(14), .DIN1_WIDTH(12), .NUM_STAGE(NS), .KLEN(3),
      .ACC_WIDTH(32), .OUT_SHIFT(0), .DOUT_WIDTH(16), .SAT_EN(1'b1)
   ) u_sat (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .din0(din0), .din1(din1),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .dout(s_dout), .busy(s_busy)
   );

   convn_valid_mac_pipe #(
      .DIN0_WIDTH(14), .DIN1_WIDTH(12), .NUM_STAGE(NS), .KLEN(3),
      .ACC_WIDTH(32), .OUT_SHIFT(0), .DOUT_WIDTH(16), .SAT_EN(1'b0)
   ) u_wrap (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(w_in_ready),
      .din0(din0), .din1(din1),
      .out_valid(w_out_valid), .out_ready(out_ready),
      .dout(w_dout), .busy(w_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   function automatic longint wsum(input int a0, b0, a1, b1, a2, b2);
      return longint'(a0) * b0 + longint'(a1) * b1 + longint'(a2) * b2;
   endfunction

   function automatic logic [15:0] ref_dout(input longint s, input bit sat);
      longint t;
      t = s;
      if (sat && t > 32767)  return 16'h7FFF;
      if (sat && t < -32768) return 16'h8000;
      return t[15:0];
   endfunction

   task automatic drive(input int a, input int b);
      in_valid = 1'b1;
      din0     = 14'(a);
      din1     = 12'(b);
   endtask

   // Feeds one window back to back, then checks latency, result and idle.
   task automatic run_window(input string tag, input int a0, b0, a1, b1, a2, b2);
      logic [15:0] es, ew;
      int k;
      es = ref_dout(wsum(a0, b0, a1, b1, a2, b2), 1'b1);
      ew = ref_dout(wsum(a0, b0, a1, b1, a2, b2), 1'b0);
      drive(a0, b0); tick();
      drive(a1, b1); tick();
      drive(a2, b2); tick();
      in_valid = 1'b0;
      k = 0;
      for (int j = 1; j <= 8; j++) begin
         @(negedge ap_clk);
         if (j == 1) chk({tag, "_busy_inflight"}, 32'(s_busy), 32'(1));
         if (s_out_valid) begin
            k = j;
            break;
         end
         tick();
      end
      chk({tag, "_latency"}, 32'(k), 32'(NS + 1));
      chk({tag, "_dout_sat"}, 32'(s_dout), 32'(es));
      chk({tag, "_dout_wrap"}, 32'(w_dout), 32'(ew));
      chk({tag, "_busy_done"}, 32'(s_busy), 32'(0));
      tick();
      @(negedge ap_clk);
      chk({tag, "_valid_1cyc"}, 32'(s_out_valid), 32'(0));
      tick();
   endtask

   initial begin : wdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ta[6];
      int          tb6[6];
      logic [15:0] expq[$];
      int          idx, hs, ra[3], rb[3];
      logic        exp_rdy, exp_v;

      // Reset state
      #3;
      chk("rst_out_valid", 32'(s_out_valid), 32'(0));
      chk("rst_busy",      32'(s_busy),      32'(0));
      chk("rst_dout",      32'(s_dout),      32'(0));
      chk("rst_in_ready",  32'(s_in_ready),  32'(1));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      tick();

      // Basic window
      run_window("basic", 3, 4, -2, 5, 7, -1);

      // Saturation / wrap
      run_window("sat_pos", 8191, 2047, 8191, 2047, 8191, 2047);
      run_window("sat_neg", -8192, 2047, -8192, 2047, -8192, 2047);

      // Backpressure across two windows
      ta  = '{3, -2, 7, 1, 1, 1};
      tb6 = '{4, 5, -1, 1, 1, 1};
      expq.delete();
      expq.push_back(ref_dout(wsum(ta[0], tb6[0], ta[1], tb6[1], ta[2], tb6[2]), 1'b1));
      expq.push_back(ref_dout(wsum(ta[3], tb6[3], ta[4], tb6[4], ta[5], tb6[5]), 1'b1));
      idx = 0;
      hs  = 0;
      for (int c = 0; c < 20; c++) begin
         exp_rdy   = !(c >= 5 && c <= 9);
         out_ready = exp_rdy;
         if (idx < 6) drive(ta[idx], tb6[idx]);
         else in_valid = 1'b0;
         @(negedge ap_clk);
         chk("bp_in_ready", 32'(s_in_ready), 32'(exp_rdy));
         if (c == 5) chk("bp_first_valid", 32'(s_out_valid), 32'(1));
         if (s_out_valid) begin
            if (expq.size() == 0) chk("bp_extra_out", 32'(expq.size()), 32'(1));
            else begin
               chk("bp_dout", 32'(s_dout), 32'(expq[0]));
               if (out_ready) begin
                  void'(expq.pop_front());
                  hs++;
               end
            end
         end
         if (in_valid && exp_rdy) idx++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_windows_out", 32'(hs), 32'(2));
      chk("bp_taps_used", 32'(idx), 32'(6));

      // Asynchronous reset mid-window
      drive(100, 100); tick();
      tick();
      in_valid = 1'b0;
      @(negedge ap_clk);
      chk("rstmid_busy_before", 32'(s_busy), 32'(1));
      #2 ap_rst_n = 1'b0;
      #1;
      chk("rstmid_out_valid", 32'(s_out_valid), 32'(0));
      chk("rstmid_busy",      32'(s_busy),      32'(0));
      chk("rstmid_dout",      32'(w_dout),      32'(0));
      @(posedge ap_clk);
      #2 ap_rst_n = 1'b1;
      tick();
      run_window("after_rst", 1, 1, 1, 1, 1, 1);

      // clr abort, with a same-edge tap that must be dropped
      drive(50, 50); tick();
      clr = 1'b1;
      drive(5, 5); tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      @(negedge ap_clk);
      chk("clr_busy",      32'(s_busy),      32'(0));
      chk("clr_out_valid", 32'(s_out_valid), 32'(0));
      tick();
      run_window("after_clr", 2, 3, 2, 3, 2, 3);

      // Back-to-back windows
      ta  = '{1, 1, 1, 2, 2, 2};
      tb6 = '{1, 1, 1, 2, 2, 2};
      expq.delete();
      expq.push_back(ref_dout(wsum(1, 1, 1, 1, 1, 1), 1'b1));
      expq.push_back(ref_dout(wsum(2, 2, 2, 2, 2, 2), 1'b1));
      for (int c = 0; c < 12; c++) begin
         if (c < 6) drive(ta[c], tb6[c]);
         else in_valid = 1'b0;
         @(negedge ap_clk);
         exp_v = (c == 2 + NS + 1) || (c == 5 + NS + 1);
         if (c < 6) chk("b2b_in_ready", 32'(s_in_ready), 32'(1));
         chk("b2b_out_valid", 32'(s_out_valid), 32'(exp_v));
         if (s_out_valid && expq.size() > 0) begin
            chk("b2b_dout", 32'(s_dout), 32'(expq[0]));
            void'(expq.pop_front());
         end
         tick();
      end
      chk("b2b_all_out", 32'(expq.size()), 32'(0));

      // Randomized windows against the arithmetic model
      for (int w = 0; w < 8; w++) begin
         for (int i = 0; i < 3; i++) begin
            ra[i] = int'($urandom_range(16383)) - 8192;
            rb[i] = int'($urandom_range(4095)) - 2048;
         end
         run_window("rand", ra[0], rb[0], ra[1], rb[1], ra[2], rb[2]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
